// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_set_ctrl
// Brief    : Mode/advance sequencer and alarm ring FSM for the alarm clock.
//            Optional held-button auto-repeat is built when AUTO_REPEAT_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
module clock_set_ctrl #(
  parameter int BUZZ_LEN   = 30,
  parameter int REPEAT_DLY = 2,
  parameter int REPEAT_PER = 1
) (
  input  logic       Pulse,
  input  logic       Reset,
  input  logic       Timeset,
  input  logic       Alarmset,
  input  logic       Minadv,
  input  logic       Hrsadv,
  input  logic       Dayadv,
  input  logic       Monthadv,
  input  logic       Dateadv,
  input  logic       Alarmon,
  input  logic       Match,
  output logic [1:0] Mode,
  output logic       TMinEn,
  output logic       THrsEn,
  output logic       TDayEn,
  output logic       TMonthEn,
  output logic       TDateEn,
  output logic       AMinEn,
  output logic       AHrsEn,
  output logic       SecClr,
  output logic       SecHold,
  output logic       DispAlarm,
  output logic       Buzz
);

  localparam int NBTN = 5;
  localparam logic [5:0] RING_LAST = 6'(BUZZ_LEN - 1);

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_TSET = 2'b01,
    MODE_ASET = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    RING_IDLE    = 2'b00,
    RING_ACTIVE  = 2'b01,
    RING_LOCKOUT = 2'b10
  } ring_e;

  if (BUZZ_LEN < 1 || BUZZ_LEN > 63 || REPEAT_DLY < 1 || REPEAT_DLY > 15 ||
      REPEAT_PER < 1 || REPEAT_PER > 15) begin : g_param_check
    $error("clock_set_ctrl: parameter out of range");
  end

  mode_e            mode_q, mode_d;
  ring_e            ring_q, ring_d;
  logic [5:0]       ring_cnt_q, ring_cnt_d;
  logic [NBTN-1:0]  hist_q;
  logic [NBTN-1:0]  btn, btn_rise, adv;
  logic             tmin_en_q, thrs_en_q, tday_en_q, tmonth_en_q, tdate_en_q;
  logic             tmin_en_d, thrs_en_d, tday_en_d, tmonth_en_d, tdate_en_d;
  logic             amin_en_q, ahrs_en_q, amin_en_d, ahrs_en_d;
  logic             sec_clr_q, sec_hold_q, disp_alarm_q, buzz_q;
  logic             sec_clr_d, sec_hold_d, disp_alarm_d, buzz_d;
  logic             in_tset, in_aset;

  // Bit order: 0 min, 1 hours, 2 day, 3 month, 4 date.
  assign btn      = {Dateadv, Monthadv, Dayadv, Hrsadv, Minadv};
  assign btn_rise = btn & ~hist_q;

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_RUN: begin
        if (Timeset)       mode_d = MODE_TSET;
        else if (Alarmset) mode_d = MODE_ASET;
      end
      MODE_TSET: if (!Timeset)  mode_d = MODE_RUN;
      MODE_ASET: if (!Alarmset) mode_d = MODE_RUN;
      default:   mode_d = MODE_RUN;
    endcase
  end

  assign in_tset = (mode_d == MODE_TSET);
  assign in_aset = (mode_d == MODE_ASET);

`ifdef AUTO_REPEAT_EN
  localparam logic [3:0] RPT_DLY = 4'(REPEAT_DLY);
  localparam logic [3:0] RPT_PER = 4'(REPEAT_PER);

  logic [3:0]      rpt_q [NBTN];
  logic [3:0]      rpt_d [NBTN];
  logic [NBTN-1:0] rpt_fire;

  // Each counter holds the cycles left until the next repeat pulse; it only
  // arms on a fresh edge inside a set mode, so a button held across mode
  // entry stays silent.
  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      rpt_d[i]    = 4'd0;
      rpt_fire[i] = 1'b0;
      if (btn[i] && mode_d != MODE_RUN) begin
        if (btn_rise[i]) begin
          rpt_d[i] = RPT_DLY;
        end else if (rpt_q[i] == 4'd1) begin
          rpt_fire[i] = 1'b1;
          rpt_d[i]    = RPT_PER;
        end else if (rpt_q[i] != 4'd0) begin
          rpt_d[i] = rpt_q[i] - 4'd1;
        end
      end
    end
  end

  assign adv = btn_rise | rpt_fire;
`else
  assign adv = btn_rise;
`endif

  always_comb begin
    tmin_en_d    = adv[0] & in_tset;
    thrs_en_d    = adv[1] & in_tset;
    tday_en_d    = adv[2] & in_tset;
    tmonth_en_d  = adv[3] & in_tset;
    tdate_en_d   = adv[4] & in_tset;
    amin_en_d    = adv[0] & in_aset;
    ahrs_en_d    = adv[1] & in_aset;
    sec_clr_d    = in_tset;
    sec_hold_d   = in_tset;
    disp_alarm_d = in_aset;
  end

  // Leaving RUN aborts a ring on the same edge that changes the mode.
  always_comb begin
    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;
    case (ring_q)
      RING_IDLE: begin
        if (Match && Alarmon && mode_d == MODE_RUN) begin
          ring_d     = RING_ACTIVE;
          ring_cnt_d = 6'd0;
        end
      end
      RING_ACTIVE: begin
        if (mode_d != MODE_RUN || !Alarmon || ring_cnt_q == RING_LAST) begin
          ring_d = RING_LOCKOUT;
        end else begin
          ring_cnt_d = ring_cnt_q + 6'd1;
        end
      end
      RING_LOCKOUT: if (!Match) ring_d = RING_IDLE;
      default:      ring_d = RING_IDLE;
    endcase
    buzz_d = (ring_d == RING_ACTIVE);
  end

  always_ff @(posedge Pulse or negedge Reset) begin
    if (!Reset) begin
      mode_q       <= MODE_RUN;
      ring_q       <= RING_IDLE;
      ring_cnt_q   <= 6'd0;
      hist_q       <= '0;
      tmin_en_q    <= 1'b0;
      thrs_en_q    <= 1'b0;
      tday_en_q    <= 1'b0;
      tmonth_en_q  <= 1'b0;
      tdate_en_q   <= 1'b0;
      amin_en_q    <= 1'b0;
      ahrs_en_q    <= 1'b0;
      sec_clr_q    <= 1'b0;
      sec_hold_q   <= 1'b0;
      disp_alarm_q <= 1'b0;
      buzz_q       <= 1'b0;
`ifdef AUTO_REPEAT_EN
      for (int i = 0; i < NBTN; i++) rpt_q[i] <= 4'd0;
`endif
    end else begin
      mode_q       <= mode_d;
      ring_q       <= ring_d;
      ring_cnt_q   <= ring_cnt_d;
      hist_q       <= btn;
      tmin_en_q    <= tmin_en_d;
      thrs_en_q    <= thrs_en_d;
      tday_en_q    <= tday_en_d;
      tmonth_en_q  <= tmonth_en_d;
      tdate_en_q   <= tdate_en_d;
      amin_en_q    <= amin_en_d;
      ahrs_en_q    <= ahrs_en_d;
      sec_clr_q    <= sec_clr_d;
      sec_hold_q   <= sec_hold_d;
      disp_alarm_q <= disp_alarm_d;
      buzz_q       <= buzz_d;
`ifdef AUTO_REPEAT_EN
      for (int i = 0; i < NBTN; i++) rpt_q[i] <= rpt_d[i];
`endif
    end
  end

  assign Mode      = mode_q;
  assign TMinEn    = tmin_en_q;
  assign THrsEn    = thrs_en_q;
  assign TDayEn    = tday_en_q;
  assign TMonthEn  = tmonth_en_q;
  assign TDateEn   = tdate_en_q;
  assign AMinEn    = amin_en_q;
  assign AHrsEn    = ahrs_en_q;
  assign SecClr    = sec_clr_q;
  assign SecHold   = sec_hold_q;
  assign DispAlarm = disp_alarm_q;
  assign Buzz      = buzz_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_set_ctrl
// Brief    : Directed and random stimulus against a cycle-level reference
//            model of the clock set controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_set_ctrl;

  localparam int BUZZ_LEN   = 30;
  localparam int REPEAT_DLY = 2;
  localparam int REPEAT_PER = 1;

  logic Pulse, Reset, Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Monthadv;
  logic Dateadv, Alarmon, Match;
  logic [1:0] Mode;
  logic TMinEn, THrsEn, TDayEn, TMonthEn, TDateEn, AMinEn, AHrsEn;
  logic SecClr, SecHold, DispAlarm, Buzz;

  clock_set_ctrl #(
    .BUZZ_LEN   (BUZZ_LEN),
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) dut (
    .Pulse     (Pulse),
    .Reset     (Reset),
    .Timeset   (Timeset),
    .Alarmset  (Alarmset),
    .Minadv    (Minadv),
    .Hrsadv    (Hrsadv),
    .Dayadv    (Dayadv),
    .Monthadv  (Monthadv),
    .Dateadv   (Dateadv),
    .Alarmon   (Alarmon),
    .Match     (Match),
    .Mode      (Mode),
    .TMinEn    (TMinEn),
    .THrsEn    (THrsEn),
    .TDayEn    (TDayEn),
    .TMonthEn  (TMonthEn),
    .TDateEn   (TDateEn),
    .AMinEn    (AMinEn),
    .AHrsEn    (AHrsEn),
    .SecClr    (SecClr),
    .SecHold   (SecHold),
    .DispAlarm (DispAlarm),
    .Buzz      (Buzz)
  );

  initial begin
    Pulse = 1'b0;
    forever #5 Pulse = ~Pulse;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: mode as 0=run 1=tset 2=aset, ring tracked as
  // "ringing for N cycles so far" plus a lockout flag.
  int       m_mode;
  bit [4:0] m_prev;
  bit       m_ringing, m_locked;
  int       m_ring_n;
  int       m_k[5];
  bit [1:0] e_mode;
  bit [6:0] e_en;
  bit       e_tset, e_aset, e_buzz;

  function automatic void model_reset();
    m_mode = 0; m_prev = '0; m_ringing = 0; m_locked = 0; m_ring_n = 0;
    for (int i = 0; i < 5; i++) m_k[i] = -1;
    e_mode = '0; e_en = '0; e_tset = 0; e_aset = 0; e_buzz = 0;
  endfunction

  function automatic void model_step();
    int       nm;
    bit [4:0] b, fire;
    b  = {Dateadv, Monthadv, Dayadv, Hrsadv, Minadv};
    if (m_mode == 0)      nm = Timeset ? 1 : (Alarmset ? 2 : 0);
    else if (m_mode == 1) nm = Timeset ? 1 : 0;
    else                  nm = Alarmset ? 2 : 0;
    fire = b & ~m_prev;
`ifdef AUTO_REPEAT_EN
    for (int i = 0; i < 5; i++) begin
      if (!b[i] || nm == 0) m_k[i] = -1;
      else if (fire[i]) m_k[i] = 0;
      else if (m_k[i] >= 0) begin
        m_k[i]++;
        if (m_k[i] >= REPEAT_DLY && (m_k[i] - REPEAT_DLY) % REPEAT_PER == 0) fire[i] = 1'b1;
      end
    end
`endif
    e_en = '0;
    if (nm == 1) e_en = {fire[0], fire[1], fire[2], fire[3], fire[4], 2'b00};
    if (nm == 2) e_en = {5'b00000, fire[0], fire[1]};
    e_tset = (nm == 1);
    e_aset = (nm == 2);
    if (m_ringing) begin
      if (nm != 0 || !Alarmon || m_ring_n >= BUZZ_LEN) begin
        m_ringing = 0; m_locked = 1;
      end else m_ring_n++;
    end else if (m_locked) begin
      if (!Match) m_locked = 0;
    end else if (Match && Alarmon && nm == 0) begin
      m_ringing = 1; m_ring_n = 1;
    end
    e_buzz = m_ringing;
    e_mode = 2'(nm);
    m_prev = b;
    m_mode = nm;
  endfunction

  task automatic step();
    @(posedge Pulse);
    model_step();
    #1;
    check_eq("mode", 16'(Mode), 16'(e_mode));
    check_eq("adv_en", 16'({TMinEn, THrsEn, TDayEn, TMonthEn, TDateEn, AMinEn, AHrsEn}), 16'(e_en));
    check_eq("sec_disp", 16'({SecClr, SecHold, DispAlarm}), 16'({e_tset, e_tset, e_aset}));
    check_eq("buzz", 16'(Buzz), 16'(e_buzz));
  endtask

  // Called just after a sampling point; asserts reset away from any edge.
  task automatic async_reset();
    #2 Reset = 1'b0;
    #1;
    check_eq("rst_outs", 16'({Mode, TMinEn, THrsEn, TDayEn, TMonthEn, TDateEn, AMinEn,
                              AHrsEn, SecClr, SecHold, DispAlarm, Buzz}), 16'h0000);
    model_reset();
    @(negedge Pulse);
    Reset = 1'b1;
  endtask

  function automatic void set_btns(input bit [4:0] b);
    {Dateadv, Monthadv, Dayadv, Hrsadv, Minadv} = b;
  endfunction

  int cnt_a, cnt_b;
  bit [4:0] rb;

  initial begin
    Reset = 1'b0; Timeset = 0; Alarmset = 0; Alarmon = 0; Match = 0;
    set_btns(5'b0);
    model_reset();
    repeat (2) @(posedge Pulse);
    #3;
    check_eq("reset_state", 16'({Mode, TMinEn, THrsEn, TDayEn, TMonthEn, TDateEn, AMinEn,
                                 AHrsEn, SecClr, SecHold, DispAlarm, Buzz}), 16'h0000);
    @(negedge Pulse);
    Reset = 1'b1;
    step();

    // Time-set with a single Minadv press in the second cycle.
    Timeset = 1; cnt_a = 0; cnt_b = 0;
    for (int c = 1; c <= 5; c++) begin
      Minadv = (c == 2);
      step();
      cnt_a += int'(TMinEn);
      cnt_b += int'(SecClr & SecHold);
      check_eq("tset_amin", 16'(AMinEn), 16'h0);
    end
    check_eq("tset_tmin_pulses", 16'(cnt_a), 16'd1);
    check_eq("tset_secclr_cycles", 16'(cnt_b), 16'd5);
    Minadv = 0; Timeset = 0;
    step();

    // Alarm-set with Hrsadv held six cycles.
    Alarmset = 1;
    step();
    check_eq("aset_disp", 16'(DispAlarm), 16'h1);
    Hrsadv = 1; cnt_a = 0; cnt_b = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      cnt_a += int'(AHrsEn);
      cnt_b += int'(THrsEn);
    end
`ifdef AUTO_REPEAT_EN
    check_eq("aset_ahrs_pulses", 16'(cnt_a), 16'd5);
`else
    check_eq("aset_ahrs_pulses", 16'(cnt_a), 16'd1);
`endif
    check_eq("aset_thrs_pulses", 16'(cnt_b), 16'd0);
    Hrsadv = 0; Alarmset = 0;
    step();

    // Full-length ring, then lockout until Match falls.
    Alarmon = 1; Match = 1; cnt_a = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      cnt_a += int'(Buzz);
    end
    check_eq("ring_len", 16'(cnt_a), 16'(BUZZ_LEN));
    Match = 0;
    step();
    step();
    Match = 1;
    for (int c = 0; c < 4; c++) step();
    check_eq("ring_retrigger", 16'(Buzz), 16'h1);
    Alarmon = 0;
    step();
    check_eq("ring_cancel", 16'(Buzz), 16'h0);
    Alarmon = 1; cnt_a = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      cnt_a += int'(Buzz);
    end
    check_eq("lockout_no_ring", 16'(cnt_a), 16'd0);

    // Reset mid-ring.
    Match = 0;
    step();
    Match = 1;
    step();
    step();
    check_eq("ring_before_reset", 16'(Buzz), 16'h1);
    async_reset();
    Match = 0;
    step();
    check_eq("mode_after_reset", 16'(Mode), 16'h0);

    // Randomized traffic.
    rb = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) Timeset  = ~Timeset;
      if ($urandom_range(0, 15) == 0) Alarmset = ~Alarmset;
      if ($urandom_range(0, 39) == 0) Match    = ~Match;
      if ($urandom_range(0, 59) == 0) Alarmon  = ~Alarmon;
      if ($urandom_range(0, 3) == 0) rb = 5'($urandom_range(0, 31));
      set_btns(rb);
      step();
      if ($urandom_range(0, 599) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
